lfsr_prbs_sequencer: RTL and testbench

//  Controller that owns and sequences a 5-bit internal-XOR LFSR (x^5+x^2+1) as a shared PRBS source.

---
 rtl/lfsr_prbs_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_lfsr_prbs_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_sequencer.sv
// lfsr_prbs_sequencer
// Owns a 5-bit Galois LFSR (x^5 + x^2 + 1) and runs it as a shared PRBS source.
// The block handles four jobs:
//   - seed loading, with all-zero lockup protection;
//   - start/stop control;
//   - packing WORD_BITS output bits into a word, first bit in the MSB;
//   - delivering each finished word on a valid/ready handshake.
// The LFSR advances only while the controller is in RUN. While a word waits
// for its consumer, the LFSR, the word and the period position stay frozen.

module lfsr_prbs_sequencer #(
  parameter int         WORD_BITS    = 8,
  parameter logic [4:0] DEFAULT_SEED = 5'b00001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 seed_load,
  input  logic [4:0]           seed_in,
  input  logic                 word_ready,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word,
  output logic [4:0]           lfsr_state,
  output logic                 busy,
  output logic                 period_wrap,
  output logic                 lockup_err
);

  // Bit counter wide enough to index every bit position of a word.
  localparam int                CNT_W    = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

  // A maximal-length 5-bit LFSR repeats every 31 steps, so the period
  // position runs 0..30.
  localparam logic [4:0]        PERIOD_LAST = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_VALID = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [4:0]             lfsr_q;
  logic [WORD_BITS-1:0]   word_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [4:0]             period_cnt_q;
  logic                   stop_pending_q;
  logic                   word_valid_q;
  logic                   busy_q;
  logic                   period_wrap_q;
  logic                   lockup_err_q;

  // ---------------------------------------------------------------------------
  // Combinational next values of the datapath
  // ---------------------------------------------------------------------------
  logic [4:0]             lfsr_step_d;
  logic [WORD_BITS-1:0]   word_shift_d;
  logic [4:0]             period_cnt_d;
  logic [4:0]             seed_d;
  logic                   seed_is_zero;
  logic                   step_en;
  logic                   handshake;

  // Work out the next LFSR value, the shifted word and the seed to load.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    lfsr_step_d  = '0;
    word_shift_d = '0;
    period_cnt_d = '0;
    seed_d       = DEFAULT_SEED;
    seed_is_zero = 1'b0;
    step_en      = 1'b0;
    handshake    = 1'b0;

    // Internal-XOR step: the bit leaving S4 feeds S0 and is XORed into S2.
    lfsr_step_d  = {lfsr_q[3], lfsr_q[2], lfsr_q[1] ^ lfsr_q[4], lfsr_q[0], lfsr_q[4]};

    // The bit leaving the LFSR (S4 before the step) enters the word LSB,
    // so the first bit generated ends up in the MSB.
    word_shift_d = {word_q[WORD_BITS-2:0], lfsr_q[4]};

    period_cnt_d = (period_cnt_q == PERIOD_LAST) ? 5'd0 : period_cnt_q + 5'd1;

    // An all-zero seed would lock the LFSR at zero, so the default seed
    // is loaded in its place.
    seed_is_zero = (seed_in == 5'd0);
    seed_d       = seed_is_zero ? DEFAULT_SEED : seed_in;

    // A stop in RUN takes effect at once, so that cycle does not step.
    step_en      = (state_q == S_RUN) && !stop;
    handshake    = (state_q == S_VALID) && word_ready;
  end

  // Controller FSM plus LFSR, word and period registers, all updated together.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments, so every register here sees the values from before this edge.
      state_q        <= S_IDLE;
      lfsr_q         <= DEFAULT_SEED;
      word_q         <= '0;
      bit_cnt_q      <= '0;
      period_cnt_q   <= '0;
      stop_pending_q <= 1'b0;
      word_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      period_wrap_q  <= 1'b0;
      lockup_err_q   <= 1'b0;
    end else begin
      // period_wrap is a one-cycle pulse unless a wrapping step sets it.
      period_wrap_q <= 1'b0;

      if (step_en) begin
        lfsr_q        <= lfsr_step_d;
        word_q        <= word_shift_d;
        period_cnt_q  <= period_cnt_d;
        period_wrap_q <= (period_cnt_q == PERIOD_LAST);
      end

      unique case (state_q)
        S_IDLE: begin
          // Priority order: stop, then seed_load, then start.
          if (stop) begin
            state_q <= S_IDLE;
          end else if (seed_load) begin
            lfsr_q       <= seed_d;
            lockup_err_q <= seed_is_zero;
            period_cnt_q <= '0;
          end else if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            bit_cnt_q <= '0;
          end
        end

        S_RUN: begin
          if (stop) begin
            // Drop the partial word; the LFSR keeps the value it reached.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
              state_q      <= S_VALID;
              word_valid_q <= 1'b1;
            end
          end
        end

        S_VALID: begin
          if (handshake) begin
            word_valid_q <= 1'b0;
            if (stop_pending_q || stop) begin
              state_q        <= S_IDLE;
              busy_q         <= 1'b0;
              stop_pending_q <= 1'b0;
            end else begin
              state_q   <= S_RUN;
              bit_cnt_q <= '0;
            end
          end else if (stop) begin
            // The waiting word is still delivered; the stop takes effect
            // once the consumer accepts it.
            stop_pending_q <= 1'b1;
          end
        end

        default: begin
          state_q        <= S_IDLE;
          busy_q         <= 1'b0;
          word_valid_q   <= 1'b0;
          stop_pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_valid  = word_valid_q;
  assign word        = word_q;
  assign lfsr_state  = lfsr_q;
  assign busy        = busy_q;
  assign period_wrap = period_wrap_q;
  assign lockup_err  = lockup_err_q;

endmodule

// File: tb/tb_lfsr_prbs_sequencer.sv
// Testbench for lfsr_prbs_sequencer.
// The reference model works in polynomial terms: a step multiplies the state
// by x modulo x^5 + x^2 + 1, and the emitted bit is the x^4 coefficient
// before the step. Words are built arithmetically, and the period is counted
// as total steps modulo 31. The model is updated on every clock edge, and
// every DUT output is compared against it one time unit after that edge.

module tb_lfsr_prbs_sequencer;

  localparam int         W   = 8;
  localparam logic [4:0] DEF = 5'b00001;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         seed_load;
  logic [4:0]   seed_in;
  logic         word_ready;
  logic         word_valid;
  logic [W-1:0] word;
  logic [4:0]   lfsr_state;
  logic         busy;
  logic         period_wrap;
  logic         lockup_err;

  lfsr_prbs_sequencer #(
    .WORD_BITS   (W),
    .DEFAULT_SEED(DEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word       (word),
    .lfsr_state (lfsr_state),
    .busy       (busy),
    .period_wrap(period_wrap),
    .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int dut_wraps = 0;

  // Reference model state. m_mode: 0 idle, 1 generating, 2 word waiting.
  int           m_mode  = 0;
  logic [4:0]   m_lfsr  = DEF;
  logic [W-1:0] m_word  = '0;
  int           m_nbits = 0;
  int           m_steps = 0;
  bit           m_pend  = 1'b0;
  bit           m_lock  = 1'b0;
  bit           m_wrap  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiply a GF(2) polynomial by x, then reduce with x^5 = x^2 + 1.
  function automatic logic [4:0] mul_x(input logic [4:0] s);
    logic [5:0] t;
    t = {s, 1'b0};
    if (t[5]) t = t ^ 6'b100101;
    return t[4:0];
  endfunction

  task automatic model_edge();
    m_wrap = 1'b0;
    if (reset) begin
      m_mode = 0; m_lfsr = DEF; m_word = '0; m_nbits = 0;
      m_steps = 0; m_pend = 1'b0; m_lock = 1'b0;
    end else begin
      case (m_mode)
        0: if (!stop) begin
          if (seed_load) begin
            if (seed_in == 5'd0) begin m_lfsr = DEF; m_lock = 1'b1; end
            else begin m_lfsr = seed_in; m_lock = 1'b0; end
            m_steps = 0;
          end else if (start) begin
            m_mode = 1; m_nbits = 0;
          end
        end
        1: if (stop) m_mode = 0;
        else begin
          m_word = W'(m_word * 2 + m_lfsr[4]);
          m_lfsr = mul_x(m_lfsr);
          m_steps++;
          m_wrap = (m_steps % 31 == 0);
          m_nbits++;
          if (m_nbits == W) m_mode = 2;
        end
        default: if (word_ready) begin
          if (m_pend || stop) begin m_mode = 0; m_pend = 1'b0; end
          else begin m_mode = 1; m_nbits = 0; end
        end else if (stop) m_pend = 1'b1;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("word_valid",  32'(word_valid),  32'(m_mode == 2));
    check("word",        32'(word),        32'(m_word));
    check("lfsr_state",  32'(lfsr_state),  32'(m_lfsr));
    check("busy",        32'(busy),        32'(m_mode != 0));
    check("period_wrap", 32'(period_wrap), 32'(m_wrap));
    check("lockup_err",  32'(lockup_err),  32'(m_lock));
  endtask

  // One clock: the edge samples the current inputs, then the outputs are checked.
  task automatic cycle();
    logic hs;
    hs = (word_valid === 1'b1) && (word_ready === 1'b1);
    @(posedge clk);
    model_edge();
    #1;
    if (hs) xfers++;
    if (period_wrap === 1'b1) dut_wraps++;
    check_outputs();
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (word_valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    check("wait_valid_bound", 32'(word_valid), 32'd1);
  endtask

  task automatic load_seed(input logic [4:0] s);
    seed_load = 1'b1; seed_in = s;
    cycle();
    seed_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [W-1:0] cap_word;
    logic [4:0]   cap_lfsr;

    reset = 1'b1; start = 1'b0; stop = 1'b0; seed_load = 1'b0;
    seed_in = '0; word_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_lfsr",       32'(lfsr_state), 32'(DEF));
    check("rst_word",       32'(word),       32'd0);
    check("rst_busy",       32'(busy),       32'd0);

    // Test 1: first word from seed 00001.
    load_seed(5'b00001);
    pulse_start();
    wait_valid(20, n);
    check("t1_latency", 32'(n), 32'(W));
    check("t1_word",    32'(word), 32'h09);
    check("t1_lfsr",    32'(lfsr_state), 32'h0d);
    word_ready = 1'b1; stop = 1'b1;
    cycle();
    word_ready = 1'b0; stop = 1'b0;
    check("t1_idle", 32'(busy), 32'd0);

    // Test 2: a zero seed raises lockup_err; a nonzero seed clears it.
    load_seed(5'b00000);
    check("t2_lfsr_default", 32'(lfsr_state), 32'(DEF));
    check("t2_lockup_set",   32'(lockup_err), 32'd1);
    load_seed(5'b00011);
    check("t2_lockup_clr",   32'(lockup_err), 32'd0);

    // Test 3: the period is 31 steps, and period_wrap marks each wrap.
    load_seed(5'b00001);
    dut_wraps = 0;
    pulse_start();
    word_ready = 1'b1;
    for (int i = 0; i < 110; i++) begin
      cycle();
      if (period_wrap === 1'b1) check("t3_wrap_lfsr", 32'(lfsr_state), 32'd1);
    end
    check("t3_wrap_count", 32'(dut_wraps), 32'(m_steps / 31));
    stop = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 4) begin cycle(); n++; end
    stop = 1'b0;
    word_ready = 1'b0;
    check("t3_stopped", 32'(busy), 32'd0);

    // Test 4: backpressure holds the word; one ready cycle gives one transfer.
    load_seed(5'($urandom_range(1, 31)));
    pulse_start();
    wait_valid(20, n);
    cap_word = word; cap_lfsr = lfsr_state;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("t4_hold_word",  32'(word),       32'(cap_word));
      check("t4_hold_lfsr",  32'(lfsr_state), 32'(cap_lfsr));
      check("t4_hold_valid", 32'(word_valid), 32'd1);
    end
    xfers = 0;
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("t4_one_xfer", 32'(xfers), 32'd1);
    // A stop while the word waits is deferred; the word is still delivered.
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t4_stop_hold_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
    check("t4_stop_valid_drop", 32'(word_valid), 32'd0);
    check("t4_stop_idle",       32'(busy),       32'd0);

    // Test 5: stop after three RUN steps discards the partial word.
    load_seed(5'b00001);
    pulse_start();
    cycle(); cycle(); cycle();
    cap_word = word;
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t5_busy",  32'(busy),       32'd0);
    check("t5_valid", 32'(word_valid), 32'd0);
    check("t5_lfsr",  32'(lfsr_state), 32'h08);
    check("t5_word",  32'(word),       32'(cap_word));
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    check("t5_start_stop_idle", 32'(busy), 32'd0);

    // Test 6: reset in VALID and in RUN.
    pulse_start();
    wait_valid(20, n);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6v_valid", 32'(word_valid), 32'd0);
    check("t6v_busy",  32'(busy),       32'd0);
    check("t6v_lfsr",  32'(lfsr_state), 32'(DEF));
    load_seed(5'b00111);
    pulse_start();
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t6r_busy", 32'(busy),       32'd0);
    check("t6r_lfsr", 32'(lfsr_state), 32'(DEF));
    check("t6r_word", 32'(word),       32'd0);

    // Randomized traffic, compared with the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      stop       = ($urandom_range(0, 15) == 0);
      seed_load  = ($urandom_range(0, 7) == 0);
      seed_in    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      start      = ($urandom_range(0, 2) == 0);
      word_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
